// File: rtl/quad_emitter.sv
// rtl/quad_emitter.sv - quadrature A/B step emitter driven by paced step commands
// Optional contact-bounce emulation: define QUAD_BOUNCE_EN.
module quad_emitter #(
    parameter int COUNT_W       = 8,
    parameter int PERIOD_W      = 16,
    parameter int BOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [COUNT_W-1:0]  cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    output logic                enc_a,
    output logic                enc_b,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t              state_q, state_d;
    logic                dir_q, dir_d;
    logic [COUNT_W-1:0]  rem_q, rem_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [PERIOD_W-1:0] pace_q, pace_d;
    logic [1:0]          ab_q, ab_d;

    logic [PERIOD_W-1:0] period_eff;
    logic [1:0]          ab_next;
    logic                expire;

    assign period_eff = (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;
    assign expire     = (state_q == S_RUN) && (pace_q == PERIOD_W'(1));
    // {a,b}: CW walks 00->10->11->01, CCW walks the reverse
    assign ab_next    = dir_q ? {~ab_q[0], ab_q[1]} : {ab_q[0], ~ab_q[1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            per_q   <= '0;
            pace_q  <= '0;
            ab_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            per_q   <= per_d;
            pace_q  <= pace_d;
            ab_q    <= ab_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        per_d   = per_q;
        pace_d  = pace_q;
        ab_d    = ab_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    dir_d   = cmd_dir;
                    rem_d   = cmd_steps;
                    per_d   = period_eff;
                    pace_d  = period_eff;
                    state_d = (cmd_steps == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (expire) begin
                    ab_d   = ab_next;
                    rem_d  = rem_q - COUNT_W'(1);
                    pace_d = per_q;
                    if (rem_q == COUNT_W'(1)) begin
                        state_d = S_FIN;
                    end
                end else begin
                    pace_d = pace_q - PERIOD_W'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_FIN);
    end

`ifdef QUAD_BOUNCE_EN
    localparam int BW = $clog2(BOUNCE_CYCLES + 2);

    logic [BW-1:0] bnc_q, bnc_d;
    logic [1:0]    out_q, out_d;
    logic [1:0]    chg_q, chg_d;
    logic [31:0]   win_w;

    // Window is capped at P-1 so it always settles before the next transition
    assign win_w = ((32'(per_q) - 32'd1) < 32'(BOUNCE_CYCLES)) ?
                   (32'(per_q) - 32'd1) : 32'(BOUNCE_CYCLES);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bnc_q <= '0;
            out_q <= 2'b00;
            chg_q <= 2'b00;
        end else begin
            bnc_q <= bnc_d;
            out_q <= out_d;
            chg_q <= chg_d;
        end
    end

    always_comb begin
        bnc_d = bnc_q;
        out_d = out_q;
        chg_d = chg_q;
        if (expire) begin
            out_d = ab_next;
            chg_d = ab_next ^ ab_q;
            bnc_d = BW'(win_w);
        end else if (bnc_q != '0) begin
            bnc_d = bnc_q - BW'(1);
            out_d = (bnc_q == BW'(1)) ? ab_q : (out_q ^ chg_q);
        end
    end

    assign enc_a = out_q[1];
    assign enc_b = out_q[0];
`else
    assign enc_a = ab_q[1];
    assign enc_b = ab_q[0];
`endif

endmodule
